// File: rtl/serial_bit_tx_pkg.sv
// Shared definitions for the serial bit transmitter: FSM states, line levels
// and a counter-width helper.
package serial_bit_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic LineIdle  = 1'b1;
    localparam logic LineStart = 1'b0;

    // A counter for n states needs at least one bit, even when n == 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_tx_bit_period_counter.sv
// Bit-period timer: counts clocks within one bit and pulses tick_o on the
// last clock of each bit. Held at zero while disabled.
module serial_bit_tx_bit_period_counter
    import serial_bit_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!en_i || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-in, serial-out transmitter: start bit, DATA_W data bits LSB first,
// optional parity bit, stop bit; each bit held CLKS_PER_BIT clocks.
module serial_bit_tx
    import serial_bit_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_line_o,
    output logic              tx_busy_o,
    output logic              tx_done_o
);

    localparam int unsigned IdxW = $clog2(DATA_W + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              parity_q, parity_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
    logic              tick;
    logic              handshake;
    logic              last_bit;

    serial_bit_tx_bit_period_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_period (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en_i  (state_q != StIdle),
        .tick_o(tick)
    );

    assign handshake = tx_valid_i && (state_q == StIdle);
    assign last_bit  = (idx_q == IdxLast);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (handshake) state_d = StStart;
            StStart:  if (tick) state_d = StData;
            StData:   if (tick && last_bit) state_d = PARITY_EN ? StParity : StStop;
            StParity: if (tick) state_d = StStop;
            StStop:   if (tick) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            line_q   <= LineIdle;
            done_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            line_q   <= line_d;
            done_q   <= done_d;
        end
    end

    // line_q is loaded with the level of the bit being entered, so the line
    // changes on the same edge as the state.
    always_comb begin
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        line_d   = line_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    shift_d  = tx_data_i;
                    parity_d = (^tx_data_i) ^ PARITY_ODD;
                    idx_d    = '0;
                    line_d   = LineStart;
                end
            end
            StStart: begin
                if (tick) line_d = shift_q[0];
            end
            StData: begin
                if (tick) begin
                    if (last_bit) begin
                        idx_d  = '0;
                        line_d = PARITY_EN ? parity_q : LineIdle;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shift_q >> 1;
                        line_d  = shift_d[0];
                    end
                end
            end
            StParity: begin
                if (tick) line_d = LineIdle;
            end
            StStop: begin
                if (tick) begin
                    line_d = LineIdle;
                    done_d = 1'b1;
                end
            end
            default: line_d = LineIdle;
        endcase
    end

    always_comb begin
        tx_ready_o = (state_q == StIdle);
        tx_busy_o  = (state_q != StIdle);
        tx_line_o  = line_q;
        tx_done_o  = done_q;
    end

endmodule
